// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: hazard sources from ID/EX/MEM in, pipeline
// control and status out. The master drives the hazard sources; the slave is the controller.
interface hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [REG_W-1:0] ex_rd;
   logic             ex_load;
   logic             ex_rf_we;
   logic             ex_branch_taken;
   logic             mem_busy;
   logic             mux_s;
   logic             pc_le;
   logic             ifid_le;
   logic             ifid_clr;
   logic             pipe_freeze;
   logic [1:0]       state;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_load, ex_rf_we,
             ex_branch_taken, mem_busy,
      input  mux_s, pc_le, ifid_le, ifid_clr, pipe_freeze, state, bubble_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_load, ex_rf_we,
             ex_branch_taken, mem_busy,
      output mux_s, pc_le, ifid_le, ifid_clr, pipe_freeze, state, bubble_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush, memory-wait
// freeze with a deferred flush, and a saturating bubble counter.
module hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             flush_pend_q, flush_pend_d;
   logic [CNT_W-1:0] cnt_q;
   logic [REG_W-1:0] ex_rd;
   logic             lu, br;
   logic             mux_s, pc_le, ifid_le, ifid_clr, pipe_freeze;

   assign ex_rd = hz.ex_rd;

   assign lu = hz.ex_load && hz.ex_rf_we && (ex_rd != '0) &&
               ((hz.id_uses_rs1 && (hz.id_rs1 == ex_rd)) ||
                (hz.id_uses_rs2 && (hz.id_rs2 == ex_rd)));

   assign br = hz.ex_branch_taken || flush_pend_q;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d      = RUN;
      flush_pend_d = flush_pend_q;
      mux_s        = 1'b0;
      pc_le        = 1'b1;
      ifid_le      = 1'b1;
      ifid_clr     = 1'b0;
      pipe_freeze  = 1'b0;

      if (hz.mem_busy) begin
         pipe_freeze = 1'b1;
         pc_le       = 1'b0;
         ifid_le     = 1'b0;
         state_d     = MEM_WAIT;
         if (hz.ex_branch_taken) flush_pend_d = 1'b1;
      end else if (br) begin
         mux_s        = 1'b1;
         ifid_clr     = 1'b1;
         flush_pend_d = 1'b0;
         state_d      = FLUSH;
      end else if (lu && (state_q != LOAD_STALL) && (state_q != FLUSH)) begin
         // A repeated match right after a stall is a stale EX; a match after a
         // flush is against a cleared ID slot. Neither earns another bubble.
         mux_s   = 1'b1;
         pc_le   = 1'b0;
         ifid_le = 1'b0;
         state_d = LOAD_STALL;
      end

      // Reset forces a safe bubble so nothing leaks into ID/EX while held.
      if (!rst_n) begin
         mux_s       = 1'b1;
         ifid_clr    = 1'b1;
         pc_le       = 1'b0;
         ifid_le     = 1'b0;
         pipe_freeze = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         flush_pend_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         if (mux_s && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign hz.mux_s       = mux_s;
   assign hz.pc_le       = pc_le;
   assign hz.ifid_le     = ifid_le;
   assign hz.ifid_clr    = ifid_clr;
   assign hz.pipe_freeze = pipe_freeze;
   assign hz.state       = state_q;
   assign hz.bubble_cnt  = cnt_q;
endmodule
